// File: rtl/arb_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_if
//  Description : Handshake bundle for the arbitrating multiplexer. Carries the
//                CH request channels (valid/ready/data) on the input side and
//                the single registered output beat (valid/ready/data/sel).
//                slave  = arbiter view, master = producer/consumer view.
//  Revision    : 1.0  initial release
// ============================================================================
interface arb_mux_if #(
  parameter int N  = 32,
  parameter int CH = 4
);

  // Select width is derived from the channel count; a single channel still
  // gets a one-bit select so the port never collapses to zero width.
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  // Request side: one valid/ready pair per channel, data flattened by channel
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [CH*N-1:0] in_data;

  // Consumer side: registered winning beat
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_data;
  logic [SW-1:0]   out_sel;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );

endinterface : arb_mux_if
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux
//  Description : Registered CH-way arbitrating multiplexer. Picks one valid
//                request per cycle (round-robin or fixed lowest-index
//                priority), accepts it into a single output register and
//                presents it with the index of the channel that supplied it.
//                Sustains one beat per cycle when the consumer drains and the
//                register refills on the same edge.
//  Revision    : 1.0  initial release
// ============================================================================
module arb_mux #(
  parameter int N  = 32,
  parameter int CH = 4,
  parameter int RR = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  arb_mux_if.slave  bus
);

  localparam int            SW       = (CH > 1) ? $clog2(CH) : 1;
  // Reset value of the round-robin pointer: the highest index, so the search
  // after reset starts at channel 0.
  localparam logic [SW-1:0] LAST_IDX = SW'(CH - 1);

  // --------------------------------------------------------------------------
  // Rotating priority search: scan CH positions beginning at 'start',
  // wrapping past CH-1 back to 0, and return {found, index} of the first
  // asserted request. Wrap is done by subtraction so non-power-of-two channel
  // counts never index past the last channel.
  // --------------------------------------------------------------------------
  function automatic logic [SW:0] find_grant(input logic [CH-1:0] valid,
                                             input logic [SW-1:0] start);
    logic          found;
    logic [SW-1:0] idx;
    int            cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 0; i < CH; i++) begin
      cand = int'(start) + i;
      if (cand >= CH) begin
        cand = cand - CH;
      end
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = SW'(cand);
      end
    end
    return {found, idx};
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] last_q,      last_d;

  // --------------------------------------------------------------------------
  // Arbitration datapath
  // --------------------------------------------------------------------------
  logic          load;          // output register can take a beat this cycle
  logic [SW-1:0] start_idx;     // first channel examined by the search
  logic          grant_found;   // at least one channel is requesting
  logic [SW-1:0] grant_idx;     // winning channel
  logic          take;          // input transfer happens on the next edge
  logic [N-1:0]  grant_data;    // data of the winning channel

  // The register is free when empty or when its current beat leaves now.
  assign load = !out_valid_q || bus.out_ready;

  // Round-robin starts one past the last accepted channel; fixed priority
  // always starts at channel 0.
  always_comb begin
    start_idx = '0;
    if (RR != 0) begin
      start_idx = (last_q == LAST_IDX) ? '0 : last_q + 1'b1;
    end
  end

  // Winner selection depends only on requests and the pointer, never on data.
  always_comb begin
    {grant_found, grant_idx} = find_grant(bus.in_valid, start_idx);
  end

  // Reset blocks acceptance so nothing is handshaken while state is cleared.
  assign take       = grant_found && load && !rst;
  assign grant_data = bus.in_data[int'(grant_idx)*N +: N];

  // One-hot ready towards the winner only; a non-requesting channel can never
  // be the winner, so it never sees ready.
  for (genvar k = 0; k < CH; k++) begin : g_ready
    assign bus.in_ready[k] = take && (grant_idx == SW'(k));
  end

  // Next-state: a fill always wins over a drain, which keeps out_valid high
  // across back-to-back beats; a drain with no fill empties the register.
  // A stall (valid and not ready) leaves everything, pointer included, as is.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_d      = last_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_sel_d   = grant_idx;
      if (RR != 0) begin
        last_d = grant_idx;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer; reset discards any pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      last_q      <= LAST_IDX;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule : arb_mux
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb_mux
//  Description : Self-checking bench for arb_mux. Two instances (round-robin
//                and fixed priority) share one stimulus stream. A vector table
//                and short hand sequences check known values; a randomized
//                phase checks both against a queue-free arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arb_mux;

  localparam int N  = 32;
  localparam int CH = 4;

  logic            clk;
  logic            rst;
  logic [CH-1:0]   iv;
  logic [CH*N-1:0] din;
  logic            ordy;

  int checks = 0;
  int errors = 0;

  arb_mux_if #(.N(N), .CH(CH)) bus_rr ();
  arb_mux_if #(.N(N), .CH(CH)) bus_fp ();

  assign bus_rr.in_valid  = iv;
  assign bus_rr.in_data   = din;
  assign bus_rr.out_ready = ordy;
  assign bus_fp.in_valid  = iv;
  assign bus_fp.in_data   = din;
  assign bus_fp.out_ready = ordy;

  arb_mux #(.N(N), .CH(CH), .RR(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  arb_mux #(.N(N), .CH(CH), .RR(0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = round-robin, 1 = fixed priority
  int          m_valid [2];
  logic [31:0] m_data  [2];
  int          m_sel   [2];
  int          m_last  [2];

  // Sampled DUT values from the latest step
  logic [CH-1:0] act_ir  [2];
  logic          act_ov  [2];
  logic [1:0]    act_sel [2];
  logic [31:0]   act_data[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First requesting channel walking upward from 'start' with wrap-around
  function automatic int pick(input logic [CH-1:0] v, input int start);
    for (int i = 0; i < CH; i++) begin
      int c;
      c = (start + i) % CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0;
      m_data[m]  = 32'h0;
      m_sel[m]   = 0;
      m_last[m]  = CH - 1;
    end
  endfunction

  // One clock: check ready before the edge, advance model, check outputs after
  task automatic step();
    int            w    [2];
    logic [CH-1:0] exp_ir[2];
    #1;
    for (int m = 0; m < 2; m++) begin
      int ld;
      ld     = (m_valid[m] == 0 || ordy) ? 1 : 0;
      w[m]   = rst ? -1 : pick(iv, (m == 0) ? (m_last[m] + 1) % CH : 0);
      if (ld == 0) w[m] = -1;
      exp_ir[m] = '0;
      if (w[m] >= 0) exp_ir[m][w[m]] = 1'b1;
    end
    act_ir[0] = bus_rr.in_ready;
    act_ir[1] = bus_fp.in_ready;
    chk("model_in_ready_rr", 32'(act_ir[0]), 32'(exp_ir[0]));
    chk("model_in_ready_fp", 32'(act_ir[1]), 32'(exp_ir[1]));
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0;
        m_data[m]  = 32'h0;
        m_sel[m]   = 0;
        m_last[m]  = CH - 1;
      end else if (w[m] >= 0) begin
        m_valid[m] = 1;
        m_data[m]  = din[w[m]*N +: N];
        m_sel[m]   = w[m];
        if (m == 0) m_last[m] = w[m];
      end else if (m_valid[m] != 0 && ordy) begin
        m_valid[m] = 0;
      end
    end
    act_ov[0]   = bus_rr.out_valid;
    act_sel[0]  = bus_rr.out_sel;
    act_data[0] = bus_rr.out_data;
    act_ov[1]   = bus_fp.out_valid;
    act_sel[1]  = bus_fp.out_sel;
    act_data[1] = bus_fp.out_data;
    for (int m = 0; m < 2; m++) begin
      chk(m == 0 ? "model_out_valid_rr" : "model_out_valid_fp", 32'(act_ov[m]), 32'(m_valid[m]));
      chk(m == 0 ? "model_out_sel_rr" : "model_out_sel_fp", 32'(act_sel[m]), 32'(m_sel[m]));
      chk(m == 0 ? "model_out_data_rr" : "model_out_data_fp", act_data[m], m_data[m]);
    end
  endtask

  typedef struct {
    logic          rst;
    logic [CH-1:0] iv;
    logic          ordy;
    logic [CH-1:0] exp_ir;
    logic          exp_ov;
    logic [1:0]    exp_sel;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[25];

  initial begin
    // Reset, single request, round-robin, backpressure, mid-operation reset
    vecs[0]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[1]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[3]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCCCC0000};
    vecs[4]  = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCCCC0002};
    vecs[5]  = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 32'hCCCC0002};
    vecs[6]  = '{1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[7]  = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCCCC0000};
    vecs[8]  = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCCCC0001};
    vecs[9]  = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCCCC0002};
    vecs[10] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hCCCC0003};
    vecs[11] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCCCC0000};
    vecs[12] = '{1'b0, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCCCC0001};
    vecs[13] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCCCC0002};
    vecs[14] = '{1'b0, 4'hF, 1'b1, 4'h8, 1'b1, 2'd3, 32'hCCCC0003};
    vecs[15] = '{1'b0, 4'h2, 1'b1, 4'h2, 1'b1, 2'd1, 32'hCCCC0001};
    vecs[16] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 32'hCCCC0001};
    vecs[17] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 32'hCCCC0001};
    vecs[18] = '{1'b0, 4'hF, 1'b0, 4'h0, 1'b1, 2'd1, 32'hCCCC0001};
    vecs[19] = '{1'b0, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCCCC0002};
    vecs[20] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 2'd2, 32'hCCCC0002};
    vecs[21] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd2, 32'hCCCC0002};
    vecs[22] = '{1'b0, 4'h4, 1'b1, 4'h4, 1'b1, 2'd2, 32'hCCCC0002};
    vecs[23] = '{1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 32'h0};
    vecs[24] = '{1'b0, 4'hF, 1'b1, 4'h1, 1'b1, 2'd0, 32'hCCCC0000};

    model_reset();
    rst  = 1'b1;
    iv   = '0;
    ordy = 1'b1;
    for (int k = 0; k < CH; k++) din[k*N +: N] = 32'hCCCC0000 + 32'(k);

    // Table phase, round-robin instance against fixed expectations
    for (int i = 0; i < 25; i++) begin
      rst  = vecs[i].rst;
      iv   = vecs[i].iv;
      ordy = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_in_ready", i), 32'(act_ir[0]), 32'(vecs[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(act_ov[0]), 32'(vecs[i].exp_ov));
      chk($sformatf("vec%0d_out_sel", i), 32'(act_sel[0]), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_out_data", i), act_data[0], vecs[i].exp_data);
    end

    // Fixed priority: channel 0 wins every cycle while it requests
    rst = 1'b0; iv = 4'hF; ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fp_all_ready", 32'(act_ir[1]), 32'h1);
      chk("fp_all_sel", 32'(act_sel[1]), 32'd0);
    end
    // Dropping channel 0 hands the grant to channel 1 on the next accept
    iv = 4'hE;
    step();
    chk("fp_drop0_ready", 32'(act_ir[1]), 32'h2);
    chk("fp_drop0_sel", 32'(act_sel[1]), 32'd1);
    chk("fp_drop0_data", act_data[1], 32'hCCCC0001);
    // Stall: no ready while the register is full and not drained
    iv = 4'h1; ordy = 1'b0;
    step();
    chk("fp_stall_ready", 32'(act_ir[1]), 32'h0);
    chk("fp_stall_sel", 32'(act_sel[1]), 32'd1);
    // Requester withdraws before acceptance; the other request wins at once
    iv = 4'h4; ordy = 1'b1;
    step();
    chk("fp_withdraw_ready", 32'(act_ir[1]), 32'h4);
    chk("fp_withdraw_sel", 32'(act_sel[1]), 32'd2);
    chk("fp_withdraw_valid", 32'(act_ov[1]), 32'd1);

    // Randomized phase against the model, both instances
    for (int i = 0; i < 600; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      iv   = CH'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < CH; k++) din[k*N +: N] = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_arb_mux
`default_nettype wire

// File: doc/arb_mux.md
# arb_mux

Registered, parametrised N-way arbitrating multiplexer with valid/ready handshakes. It replaces fixed 4:1 select muxes wherever several producers compete for one consumer, for example multiple request sources sharing a memory or bus port. Unlike a plain select mux, it decides the winner itself, using round-robin or fixed priority, and registers the chosen beat. It passes one beat per cycle under backpressure without loss or duplication.

## Interface

Parameters:

- N, 32: data width per channel.
- CH, 4: number of input channels, ≥1.
- RR, 1: arbitration mode. 1 = round-robin, 0 = fixed priority (lowest index wins).
- SW, derived: max(1, ceil(log2(CH))), width of out_sel. Not user-set.

Ports:

- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, CH: per-channel request valid.
- in_ready, output, CH: per-channel accept. At most one bit set.
- in_data, input, CH*N: flattened inputs. Channel k occupies bits [k*N +: N].
- out_valid, output, 1: out_data holds a beat.
- out_ready, input, 1: consumer accepts the beat.
- out_data, output, N: registered winning data.
- out_sel, output, SW: registered index of the channel that supplied out_data.

## Operation

- One output register holds out_valid, out_data and out_sel.
- load = !out_valid | out_ready. The register is free this cycle when it is empty or being drained.
- Grant g is computed combinationally from in_valid and the priority pointer.
  - RR=1: search starts at index (last+1) mod CH and wraps.
  - RR=0: search always starts at 0.
- in_ready[g] = load & in_valid[g] & !rst. All other in_ready bits are 0. A channel without in_valid never sees in_ready.
- Transfer in on channel g happens when in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - last <= g, only when RR=1
- Output transfer happens when out_valid & out_ready. If no input transfer happens on the same edge, out_valid <= 0.
- Simultaneous drain and fill on one edge:
  - out_valid stays 1 and the new beat replaces the old one.
  - Throughput is 1 beat per cycle.
- While out_valid=1 and out_ready=0:
  - out_data and out_sel are held stable.
  - All in_ready bits are 0.
  - last does not change.
- The pointer advances only on an accepted transfer. Requests alone, or a stall, never move it.
- If the winning channel drops in_valid before being accepted, arbitration is recomputed with no penalty.
- CH=1: the arbiter degenerates to a pass-through register and out_sel is constantly 0.
- Reset, including mid-operation:
  - out_valid=0, out_data=0, out_sel=0.
  - last=CH-1, so channel 0 has first priority.
  - A pending output beat is discarded.
  - in_ready is forced to 0 while rst=1.

## Timing

- Latency is 1 cycle from input handshake to out_valid/out_data.
- in_ready depends combinationally on in_valid, out_valid, out_ready and the pointer. There is no combinational path from in_data to any output.
- All state updates occur on the rising edge of clk. rst has priority over every transfer.
- Round-robin guarantee: with all CH channels valid continuously and out_ready=1, each channel is granted exactly once in any CH consecutive accepts.

## Test plan

All scenarios use N=32, CH=4 unless stated.

1. Reset: hold rst=1 for 2 cycles with in_valid=4'b1111.
   - In both cycles: in_ready=0.
   - After release: out_valid=0, out_data=0, out_sel=0.
   - First accept is channel 0.
2. Single request: in_valid=4'b0100, channel 2 data=32'hCCCC0002, out_ready=1.
   - Same cycle: in_ready=4'b0100.
   - Next cycle: out_valid=1, out_data=32'hCCCC0002, out_sel=2.
   - Following cycle, with in_valid=0: out_valid=0.
3. Round-robin: RR=1, in_valid=4'b1111 held, out_ready=1 for 8 cycles.
   - out_sel sequence is 0,1,2,3,0,1,2,3 with a continuous out_valid=1.
4. Backpressure: with out_valid=1 and out_sel=1, hold out_ready=0 for 3 cycles.
   - During the stall: out_data and out_sel stable, in_ready=0.
   - Raise out_ready: the beat drains and channel 2 is accepted the same cycle.
   - No beat is lost or duplicated.
5. Fixed priority: RR=0, in_valid=4'b1111, out_ready=1.
   - out_sel=0 every cycle.
   - Drop in_valid[0]: out_sel=1 from the next accept.
6. Reset mid-operation: RR=1, last accept was channel 2, out_valid=1, pulse rst for 1 cycle.
   - Next cycle: out_valid=0.
   - With in_valid=4'b1111, the next grant is channel 0, not channel 3.
